// File: rtl/march_pkg.sv
// rtl/march_pkg.sv - March C- element tables, FSM states and op helpers for march_sequencer
package march_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  localparam int NUM_ELEM = 6;
  localparam int MAX_OPS  = 2;

  typedef logic [2:0]                   elem_t;
  typedef logic [$clog2(MAX_OPS)-1:0]   op_idx_t;

  // One bit per element, bit index = element number
  localparam logic [NUM_ELEM-1:0] ELEM_DOWN    = 6'b011000;
  localparam logic [NUM_ELEM-1:0] ELEM_TWO_OPS = 6'b011110;
  localparam logic [NUM_ELEM-1:0] OP0_READ     = 6'b111110;
  localparam logic [NUM_ELEM-1:0] OP0_BIT      = 6'b010100;
  localparam logic [NUM_ELEM-1:0] OP1_BIT      = 6'b001010;

  function automatic logic op_is_read(elem_t elem, op_idx_t op);
    return (op == 1'b0) && OP0_READ[elem];
  endfunction

  function automatic logic op_is_last(elem_t elem, op_idx_t op);
    return op == op_idx_t'(ELEM_TWO_OPS[elem]);
  endfunction

  function automatic logic op_bit(elem_t elem, op_idx_t op);
    return (op != 1'b0) ? OP1_BIT[elem] : OP0_BIT[elem];
  endfunction

endpackage

// File: rtl/march_sequencer_if.sv
// rtl/march_sequencer_if.sv - single-port synchronous RAM bus between sequencer and RAM under test
interface march_sequencer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_en, output mem_we, output mem_addr, output mem_wdata, input mem_rdata);
  modport slave  (input mem_en, input mem_we, input mem_addr, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/march_addr_gen.sv
// rtl/march_addr_gen.sv - up/down address counter with load-to-start and end-of-element flag
module march_addr_gen #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              load_down_i,
  input  logic              adv_i,
  input  logic              down_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_down_i ? ADDR_MAX : '0;
    end else if (adv_i) begin
      addr_d = down_i ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) addr_q <= '0;
    else      addr_q <= addr_d;
  end

  assign addr_o = addr_q;
  assign last_o = down_i ? (addr_q == '0) : (addr_q == ADDR_MAX);
endmodule

// File: rtl/march_sequencer.sv
// rtl/march_sequencer.sv - March C- RAM BIST sequencer; MARCH_BG_EN adds a checkerboard rerun and fail_bg
module march_sequencer
  import march_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
`ifdef MARCH_BG_EN
  output logic              fail_bg,
`endif
  march_sequencer_if.master mem
);
`ifdef MARCH_BG_EN
  localparam bit BG_EN = 1'b1;
`else
  localparam bit BG_EN = 1'b0;
`endif

  state_t            state_q, state_d;
  elem_t             elem_q, elem_d, cmp_elem_q, cmp_elem_d, fail_elem_q, fail_elem_d;
  op_idx_t           op_q, op_d;
  logic              bg_q, bg_d, cmp_vld_q, cmp_vld_d;
  logic              pass_q, pass_d, fail_q, fail_d;
  logic [DATA_W-1:0] cmp_exp_q, cmp_exp_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d, fail_addr_q, fail_addr_d;
`ifdef MARCH_BG_EN
  logic              cmp_bg_q, cmp_bg_d, fail_bg_q, fail_bg_d;
`endif

  logic [ADDR_W-1:0] addr;
  logic              addr_last, addr_load, addr_load_down, addr_adv;
  logic              running, rd_op, last_op, mismatch;
  logic [DATA_W-1:0] bg_pat, op_data;

  march_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .load_i      (addr_load),
    .load_down_i (addr_load_down),
    .adv_i       (addr_adv),
    .down_i      (ELEM_DOWN[elem_q]),
    .addr_o      (addr),
    .last_o      (addr_last)
  );

  assign running  = (state_q == ST_RUN);
  assign rd_op    = op_is_read(elem_q, op_q);
  assign last_op  = op_is_last(elem_q, op_q);
  assign bg_pat   = bg_q ? {(DATA_W/2){2'b01}} : '0;
  assign op_data  = op_bit(elem_q, op_q) ? ~bg_pat : bg_pat;
  assign mismatch = cmp_vld_q && (mem.mem_rdata != cmp_exp_q);

  assign mem.mem_en    = running;
  assign mem.mem_we    = running && !rd_op;
  assign mem.mem_addr  = running ? addr : '0;
  assign mem.mem_wdata = (running && !rd_op) ? op_data : '0;

  always_comb begin
    state_d        = state_q;
    elem_d         = elem_q;
    op_d           = op_q;
    bg_d           = bg_q;
    cmp_vld_d      = 1'b0;
    cmp_exp_d      = cmp_exp_q;
    cmp_addr_d     = cmp_addr_q;
    cmp_elem_d     = cmp_elem_q;
    pass_d         = pass_q;
    fail_d         = fail_q;
    fail_addr_d    = fail_addr_q;
    fail_elem_d    = fail_elem_q;
`ifdef MARCH_BG_EN
    cmp_bg_d       = cmp_bg_q;
    fail_bg_d      = fail_bg_q;
`endif
    addr_load      = 1'b0;
    addr_load_down = 1'b0;
    addr_adv       = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_RUN;
          elem_d      = '0;
          op_d        = '0;
          bg_d        = 1'b0;
          pass_d      = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = '0;
`ifdef MARCH_BG_EN
          fail_bg_d   = 1'b0;
`endif
          addr_load   = 1'b1;
        end
      end
      ST_RUN: begin
        if (rd_op) begin
          cmp_vld_d  = 1'b1;
          cmp_exp_d  = op_data;
          cmp_addr_d = addr;
          cmp_elem_d = elem_q;
`ifdef MARCH_BG_EN
          cmp_bg_d   = bg_q;
`endif
        end
        if (!last_op) begin
          op_d = op_q + op_idx_t'(1);
        end else begin
          op_d = '0;
          if (!addr_last) begin
            addr_adv = 1'b1;
          end else if (elem_q != elem_t'(NUM_ELEM - 1)) begin
            elem_d         = elem_q + elem_t'(1);
            addr_load      = 1'b1;
            addr_load_down = ELEM_DOWN[elem_d];
          end else if (BG_EN && !bg_q) begin
            // Checkerboard pass starts back at M0 on the very next cycle
            bg_d      = 1'b1;
            elem_d    = '0;
            addr_load = 1'b1;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        // The op issued alongside a failing compare is dropped with the run
        if (mismatch) begin
          state_d     = ST_DONE;
          cmp_vld_d   = 1'b0;
          fail_d      = 1'b1;
          fail_addr_d = cmp_addr_q;
          fail_elem_d = cmp_elem_q;
`ifdef MARCH_BG_EN
          fail_bg_d   = cmp_bg_q;
`endif
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
        if (mismatch) begin
          fail_d      = 1'b1;
          fail_addr_d = cmp_addr_q;
          fail_elem_d = cmp_elem_q;
`ifdef MARCH_BG_EN
          fail_bg_d   = cmp_bg_q;
`endif
        end else begin
          pass_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      elem_q      <= '0;
      op_q        <= '0;
      bg_q        <= 1'b0;
      cmp_vld_q   <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
      cmp_elem_q  <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      op_q        <= op_d;
      bg_q        <= bg_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end

`ifdef MARCH_BG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmp_bg_q  <= 1'b0;
      fail_bg_q <= 1'b0;
    end else begin
      cmp_bg_q  <= cmp_bg_d;
      fail_bg_q <= fail_bg_d;
    end
  end

  assign fail_bg = fail_bg_q;
`endif

  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign fail_addr = fail_addr_q;
  assign fail_elem = fail_elem_q;
endmodule

// File: doc/march_sequencer.md
Name: march_sequencer

Overview:
- Drives a single-port synchronous RAM through a complete March C- test: address generation, write data, read compare and fail capture.
- Sits between the BIST control FSM and the RAM under test. The control FSM pulses start and reads done/pass/fail.
- Replaces the ad-hoc pattern/counter handshake with one self-contained sequencer that reports the first failing address and element.

Parameters:
- ADDR_W, 4, RAM address width; depth N = 2**ADDR_W.
- DATA_W, 8, RAM data width.

Ports:
- clk  in  1  Single clock; all state updates on the rising edge.
- rst  in  1  Asynchronous, active-low reset. Assertion clears all state immediately; deassertion is synchronous to clk.
- start  in  1  One-cycle request to begin a test. Ignored while busy=1.
- busy  out  1  High from the cycle after start is accepted until done rises.
- done  out  1  Level. High after the test completes or aborts; held until the next accepted start.
- pass  out  1  Valid while done=1; 1 means no mismatch was found.
- fail  out  1  Valid while done=1; always the inverse of pass when done=1.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable; meaningful only when mem_en=1.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after a read is issued.
- fail_addr  out  ADDR_W  Address of the first mismatch.
- fail_elem  out  3  March element index (0-5) of the first mismatch.

Behaviour:
- Reset values: every output is 0, and the FSM is in IDLE.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE or DONE, start=1 -> RUN. Clears done, pass, fail, fail_addr and fail_elem. Sets element=0, op=0, address=0.
  - RUN issues one RAM operation per cycle with mem_en=1.
- March C- element table:
  - M0 up (w0)
  - M1 up (r0, w1)
  - M2 up (r1, w0)
  - M3 down (r0, w1)
  - M4 down (r1, w0)
  - M5 up (r0)
- Data values: "0" = all bits 0 and "1" = all bits 1 on mem_wdata and as the expected read value.
- Address order: up runs 0 to N-1; down runs N-1 to 0.
- Operation order: all ops of an element are issued at one address before the address advances. After the last address of an element, the next element begins on the following cycle with no gap.
- Compare stage: a read issued in cycle t is compared against a registered expected value in cycle t+1.
- Mismatch handling (first mismatch only):
  - Capture fail_addr and fail_elem of the offending read.
  - Force mem_en=0 from the next cycle and go to DONE with fail=1.
  - Any op already issued in the mismatch cycle is discarded and not compared.
- Normal completion: after the final M5 read, the FSM enters DRAIN for one cycle to compare that read, then goes to DONE with pass=1 if there was no mismatch.
- Timing: start is sampled at edge k.
  - mem_en is high for cycles k+1 through k+10N.
  - On pass, done is high at k+10N+2. For ADDR_W=4 that is 160 ops, with done at cycle 162.
- Boundary conditions:
  - A mismatch on the last M5 read is still reported as fail.
  - Address counters wrap only at element boundaries and never emit an out-of-range address.
  - start asserted in the same cycle done rises is ignored.
  - Reset asserted mid-run: mem_en drops to 0 asynchronously, with no partial result.

Optional Feature:
- Macro: MARCH_BG_EN.
- With the macro defined:
  - After a passing solid-background run, a second full March C- run follows immediately with no gap.
  - The second run uses background "0" = {DATA_W/2{2'b01}} and "1" = its bitwise inverse.
  - Adds output fail_bg (1 bit, reset 0). It is set to 1 if the mismatch occurs in the checkerboard run.
  - On pass, done is high at k+20N+2.
- Without the macro: a single solid run only, and no fail_bg port.

Decomposition:
- Package march_pkg:
  - FSM state enum.
  - NUM_ELEM=6 and MAX_OPS=2.
  - Per-element constant tables: direction, op count, and per-op read/write and data-bit value.
- One natural sub-module: march_addr_gen.
  - ADDR_W-bit up/down counter with load-to-start-address.
  - Provides an advance enable and a combinational "last" flag for the current direction.

Test Plan:
- Fault-free RAM model, ADDR_W=4, start at cycle 0 -> exactly 160 mem_en cycles, in element/address order per the table; done=1 and pass=1 at cycle 162; busy=0 afterwards.
- Addr 5, bit 3 stuck-at-0 -> fail=1, fail_elem=2, fail_addr=5; mem_en=0 from the cycle after the compare.
- Addr 0, bit 0 stuck-at-1 -> fail=1, fail_elem=1, fail_addr=0.
- start re-pulsed at cycle 50 of a run -> ignored, and completion timing is unchanged (done at 162). A subsequent start after a fail clears fail and reruns to pass.
- rst driven low at cycle 80 -> all outputs 0 immediately. After release, start -> a full passing run of 162 cycles.
- MARCH_BG_EN defined, adjacent-bit coupling fault visible only with the checkerboard pattern -> solid run passes, then fail=1 and fail_bg=1. A fault-free RAM gives done at cycle 322.
